// File: rtl/sensor_debounce.sv
// Sensor pin conditioning: 2-flop synchroniser, shared sample prescaler and a
// per-channel stability filter with a sticky change flag for the sensors latch.

module sensor_debounce_lane #(
  parameter int STABLE_CNT = 4
) (
  input  logic masterClk,
  input  logic reset,
  input  logic tick,
  input  logic sample,
  input  logic latchClear,
  output logic filtered,
  output logic sensorEvent
);
  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CNT - 1);

  logic [CW-1:0] cnt;
  logic          accept;

  assign accept = tick && (sample != filtered) && (cnt == CMAX);

  always_ff @(posedge masterClk) begin
    if (reset) begin
      cnt         <= '0;
      filtered    <= 1'b0;
      sensorEvent <= 1'b0;
    end else begin
      if (tick) begin
        if (sample == filtered) begin
          cnt <= '0;
        end else if (cnt == CMAX) begin
          filtered <= sample;
          cnt      <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      // An accepted change beats a same-cycle clear so no event is lost.
      if (accept)
        sensorEvent <= 1'b1;
      else if (latchClear)
        sensorEvent <= 1'b0;
    end
  end
endmodule

module sensor_debounce #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE   = 1200,
  parameter int STABLE_CNT = 4
) (
  input  logic             masterClk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sensorRaw,
  input  logic             latchClear,
  output logic [WIDTH-1:0] sensorFiltered,
  output logic [WIDTH-1:0] sensorEvent,
  output logic             sampleTick
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] sync1, sync2;
  logic [PW-1:0]    preCnt;

  always_ff @(posedge masterClk) begin
    if (reset) begin
      sync1      <= '0;
      sync2      <= '0;
      preCnt     <= '0;
      sampleTick <= 1'b0;
    end else begin
      sync1 <= sensorRaw;
      sync2 <= sync1;
      if (preCnt == PMAX) begin
        preCnt     <= '0;
        sampleTick <= 1'b1;
      end else begin
        preCnt     <= preCnt + 1'b1;
        sampleTick <= 1'b0;
      end
    end
  end

  // Filter lanes act on the registered tick, i.e. one cycle after the wrap.
  for (genvar i = 0; i < WIDTH; i++) begin : gLane
    sensor_debounce_lane #(.STABLE_CNT(STABLE_CNT)) uLane (
      .masterClk  (masterClk),
      .reset      (reset),
      .tick       (sampleTick),
      .sample     (sync2[i]),
      .latchClear (latchClear),
      .filtered   (sensorFiltered[i]),
      .sensorEvent(sensorEvent[i])
    );
  end
endmodule

// File: tb/tb_sensor_debounce.sv
// Directed bench for sensor_debounce: main instance PRESCALE=4/STABLE_CNT=3,
// second instance PRESCALE=1/STABLE_CNT=1. Edge numbers are counted from the reset edge E0.

module tb_sensor_debounce;
  logic       masterClk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] sensorRaw = 8'h00;
  logic       latchClear = 1'b0;
  logic [7:0] sensorFiltered, sensorEvent;
  logic       sampleTick;
  logic [7:0] raw6 = 8'h00;
  logic [7:0] filt6, evt6;
  logic       tick6;

  int nAssert = 0;
  int nFail   = 0;

  always #5 masterClk = ~masterClk;

  sensor_debounce #(.WIDTH(8), .PRESCALE(4), .STABLE_CNT(3)) dut (
    .masterClk(masterClk), .reset(reset), .sensorRaw(sensorRaw), .latchClear(latchClear),
    .sensorFiltered(sensorFiltered), .sensorEvent(sensorEvent), .sampleTick(sampleTick)
  );

  sensor_debounce #(.WIDTH(8), .PRESCALE(1), .STABLE_CNT(1)) dut6 (
    .masterClk(masterClk), .reset(reset), .sensorRaw(raw6), .latchClear(1'b0),
    .sensorFiltered(filt6), .sensorEvent(evt6), .sampleTick(tick6)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge masterClk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    sensorRaw = 8'hFF; latchClear = 1'b0;
    doReset();  // E0
    nAssert++; if (sensorFiltered !== 8'h00) begin nFail++; $display("FAIL reset_filt got %h want 00", sensorFiltered); end
    nAssert++; if (sensorEvent !== 8'h00) begin nFail++; $display("FAIL reset_evt got %h want 00", sensorEvent); end
    nAssert++; if (sampleTick !== 1'b0) begin nFail++; $display("FAIL reset_tick got %b want 0", sampleTick); end
  endtask

  // Raw held FF: evaluations at E5, E9, E13 -> accepted after E13.
  task automatic test_accept();
    cyc(4);  // E4: first tick registered
    nAssert++; if (sampleTick !== 1'b1) begin nFail++; $display("FAIL first_tick got %b want 1", sampleTick); end
    cyc(5);  // E9: second tick evaluated
    nAssert++; if (sensorFiltered !== 8'h00) begin nFail++; $display("FAIL accept_2nd got %h want 00", sensorFiltered); end
    cyc(3);  // E12: third tick high
    nAssert++; if (sensorFiltered !== 8'h00) begin nFail++; $display("FAIL accept_3rd got %h want 00", sensorFiltered); end
    cyc(1);  // E13
    nAssert++; if (sensorFiltered !== 8'hFF) begin nFail++; $display("FAIL accept_filt got %h want FF", sensorFiltered); end
    nAssert++; if (sensorEvent !== 8'hFF) begin nFail++; $display("FAIL accept_evt got %h want FF", sensorEvent); end
  endtask

  // Pulse visible to ticks at E5 and E9 only.
  task automatic test_glitch();
    sensorRaw = 8'h00;
    doReset();
    cyc(2);
    sensorRaw = 8'h01;
    cyc(6);
    sensorRaw = 8'h00;
    cyc(20);
    nAssert++; if (sensorFiltered !== 8'h00) begin nFail++; $display("FAIL glitch_filt got %h want 00", sensorFiltered); end
    nAssert++; if (sensorEvent !== 8'h00) begin nFail++; $display("FAIL glitch_evt got %h want 00", sensorEvent); end
  endtask

  // Bit3 period-6 toggle: ticks at E29,E33 see 1, E37 sees 0; held 1 -> E41,E45,E49.
  task automatic test_toggle();
    sensorRaw = 8'h00;
    doReset();
    sensorRaw = 8'h08;
    for (int k = 0; k < 12; k++) begin
      cyc(3);
      sensorRaw[3] = ~sensorRaw[3];
    end
    nAssert++; if (sensorFiltered !== 8'h00) begin nFail++; $display("FAIL toggle_during got %h want 00", sensorFiltered); end
    cyc(12); // E48
    nAssert++; if (sensorFiltered !== 8'h00) begin nFail++; $display("FAIL toggle_pre got %h want 00", sensorFiltered); end
    cyc(1);  // E49
    nAssert++; if (sensorFiltered !== 8'h08) begin nFail++; $display("FAIL toggle_filt got %h want 08", sensorFiltered); end
    nAssert++; if (sensorEvent !== 8'h08) begin nFail++; $display("FAIL toggle_evt got %h want 08", sensorEvent); end
    cyc(12);
    nAssert++; if (sensorEvent !== 8'h08) begin nFail++; $display("FAIL toggle_evt_hold got %h want 08", sensorEvent); end
  endtask

  // Bit0 accepted at E13; bit1 (set after E4) accepted at E17 with latchClear.
  task automatic test_clear_collision();
    sensorRaw = 8'h00;
    doReset();
    sensorRaw = 8'h01;
    cyc(4);
    sensorRaw = 8'h03;
    cyc(12); // E16
    nAssert++; if (sensorEvent !== 8'h01) begin nFail++; $display("FAIL clr_pre_evt got %h want 01", sensorEvent); end
    latchClear = 1'b1;
    cyc(1);  // E17
    latchClear = 1'b0;
    nAssert++; if (sensorEvent !== 8'h02) begin nFail++; $display("FAIL clr_same_evt got %h want 02", sensorEvent); end
    nAssert++; if (sensorFiltered !== 8'h03) begin nFail++; $display("FAIL clr_same_filt got %h want 03", sensorFiltered); end
    cyc(1);  // E18: no tick here
    latchClear = 1'b1;
    cyc(1);  // E19
    latchClear = 1'b0;
    nAssert++; if (sensorEvent !== 8'h00) begin nFail++; $display("FAIL clr_off_tick got %h want 00", sensorEvent); end
  endtask

  // Bit2 at cnt=2 after E9; reset at E10 becomes new E0; fresh accept at E13'.
  task automatic test_mid_reset();
    sensorRaw = 8'h00;
    doReset();
    sensorRaw = 8'h04;
    cyc(9);
    doReset();
    nAssert++; if ({sensorFiltered, sensorEvent, sampleTick} !== 17'h0) begin nFail++; $display("FAIL midrst_outs got %h/%h/%b want 00/00/0", sensorFiltered, sensorEvent, sampleTick); end
    cyc(8);  // E8': stale count would have accepted by E3'
    nAssert++; if (sensorFiltered !== 8'h00) begin nFail++; $display("FAIL midrst_stale got %h want 00", sensorFiltered); end
    cyc(4);  // E12'
    nAssert++; if (sensorFiltered !== 8'h00) begin nFail++; $display("FAIL midrst_pre got %h want 00", sensorFiltered); end
    cyc(1);  // E13'
    nAssert++; if (sensorFiltered !== 8'h04) begin nFail++; $display("FAIL midrst_filt got %h want 04", sensorFiltered); end
  endtask

  // Raw presented in cycle 0 (after E3); sync at E4,E5; accepted at E6, the fourth cycle.
  task automatic test_fast_variant();
    sensorRaw = 8'h00; raw6 = 8'h00;
    doReset();
    cyc(1);
    nAssert++; if (tick6 !== 1'b1) begin nFail++; $display("FAIL fast_tick1 got %b want 1", tick6); end
    cyc(1);
    nAssert++; if (tick6 !== 1'b1) begin nFail++; $display("FAIL fast_tick2 got %b want 1", tick6); end
    cyc(1);  // E3
    raw6 = 8'hA5;
    cyc(2);  // E5
    nAssert++; if (filt6 !== 8'h00) begin nFail++; $display("FAIL fast_early got %h want 00", filt6); end
    cyc(1);  // E6
    nAssert++; if (filt6 !== 8'hA5) begin nFail++; $display("FAIL fast_filt got %h want A5", filt6); end
    nAssert++; if (evt6 !== 8'hA5) begin nFail++; $display("FAIL fast_evt got %h want A5", evt6); end
  endtask

  initial begin
    test_reset();
    test_accept();
    test_glitch();
    test_toggle();
    test_clear_collision();
    test_mid_reset();
    test_fast_variant();
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired before completion");
    $fatal(1, "timeout");
  end
endmodule
